// File: rtl/reg_dump_reader.sv
// Register-file snapshot walker: reads every register through a dedicated async port and
// streams (index, value) beats over valid/ready, stalling the core for the whole dump.
module reg_dump_reader #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              skip_zero_i,
  output logic [ADDR_W-1:0] dump_reg_o,
  input  logic [DATA_W-1:0] dump_data_i,
  output logic              cpu_stall_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_index_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   emit_count_o
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StSend, StFin} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [ADDR_W:0]     emit_q, emit_d;
  logic                skip_q, skip_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      valid_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      emit_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      index_q <= index_d;
      data_q  <= data_d;
      last_q  <= last_d;
      emit_q  <= emit_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    index_d = index_q;
    data_d  = data_q;
    last_d  = last_q;
    emit_d  = emit_q;
    skip_d  = skip_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFetch;
          idx_d   = '0;
          emit_d  = '0;
          skip_d  = skip_zero_i;
        end
      end
      StFetch: begin
        data_d  = dump_data_i;
        index_d = idx_q;
        // The final register is always emitted so the stream always carries a last beat.
        if (skip_q && (dump_data_i == '0) && (idx_q != LastIdx)) begin
          idx_d = idx_q + 1'b1;
        end else begin
          state_d = StSend;
          valid_d = 1'b1;
          last_d  = (idx_q == LastIdx);
        end
      end
      StSend: begin
        if (valid_q && out_ready_i) begin
          valid_d = 1'b0;
          emit_d  = emit_q + 1'b1;
          if (last_q) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign dump_reg_o   = idx_q;
  assign cpu_stall_o  = (state_q != StIdle);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StFin);
  assign out_valid_o  = valid_q;
  assign out_index_o  = index_q;
  assign out_data_o   = data_q;
  assign out_last_o   = last_q;
  assign emit_count_o = emit_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader with a small register-file model whose writes are
// gated by cpu_stall.
module tb_reg_dump_reader;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          skip_zero = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] dump_reg, out_index;
  logic [DW-1:0] dump_data, out_data;
  logic          cpu_stall, out_valid, out_last, busy, done;
  logic [AW:0]   emit_count;

  logic          wr_en = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] regs [N];

  int n_cmp = 0;
  int n_bad = 0;

  // run_dump observations
  int            nb, done_cnt, first_v, done_c, hold_bad;
  bit            timed_out;
  logic [AW-1:0] b_idx  [64];
  logic [DW-1:0] b_data [64];
  logic          b_last [64];
  logic          stall_log [400];

  always #5 clk = ~clk;

  assign dump_data = (dump_reg == '0) ? '0 : regs[dump_reg];

  always @(posedge clk) begin
    if (wr_en && !cpu_stall && (wa != '0)) regs[wa] <= wd;
  end

  reg_dump_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .skip_zero_i  (skip_zero),
    .dump_reg_o   (dump_reg),
    .dump_data_i  (dump_data),
    .cpu_stall_o  (cpu_stall),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_index_o  (out_index),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .busy_o       (busy),
    .done_o       (done),
    .emit_count_o (emit_count)
  );

  // mode 0: r[i]=i*3; mode 1: r[5]=DEADBEEF, everything else 0
  task automatic preload(input int mode);
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wa    = AW'(i);
      wd    = (mode == 0) ? DW'(i * 3) : ((i == 5) ? 32'hDEADBEEF : '0);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Drives one dump and records what came out; comparisons are made by the callers.
  task automatic run_dump(input bit skip, input bit bp, input int restart_beat,
                          input int wr_cycle);
    bit            pend;
    logic [AW-1:0] pi;
    logic [DW-1:0] pd;
    logic          pl;
    bit [3:0]      pat;
    pat = 4'b1001;
    nb = 0; done_cnt = 0; first_v = -1; done_c = -1; hold_bad = 0; pend = 1'b0;
    pi = '0; pd = '0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1; skip_zero = skip; out_ready = 1'b1;
    stall_log[0] = cpu_stall;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (c == wr_cycle) begin
        wr_en = 1'b1; wa = 5'd20; wd = 32'h0000FFFF;
      end
      out_ready = bp ? pat[c % 4] : 1'b1;
      stall_log[c] = cpu_stall;
      if (pend && (out_valid !== 1'b1 || out_index !== pi || out_data !== pd ||
                   out_last !== pl)) hold_bad++;
      pend = out_valid && !out_ready;
      pi = out_index; pd = out_data; pl = out_last;
      if (out_valid && first_v < 0) first_v = c;
      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (out_valid && out_ready && nb < 64) begin
        b_idx[nb] = out_index; b_data[nb] = out_data; b_last[nb] = out_last;
        nb++;
        if (nb == restart_beat) begin
          start = 1'b1; skip_zero = ~skip_zero;
        end
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    timed_out = (done_c < 0);
    out_ready = 1'b0; skip_zero = 1'b0; wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0 || cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b/%b want 0/0", busy, cpu_stall); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_cmp++; if (emit_count !== '0) begin n_bad++; $display("FAIL rst_emit got %0d want 0", emit_count); end
    n_cmp++; if (dump_reg !== '0 || out_index !== '0) begin n_bad++; $display("FAIL rst_idx got %0d/%0d want 0/0", dump_reg, out_index); end
    n_cmp++; if (out_data !== '0 || out_last !== 1'b0) begin n_bad++; $display("FAIL rst_data got %h/%b want 0/0", out_data, out_last); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_stall(input string nm);
    int bad;
    bad = 0;
    if (!timed_out) begin
      for (int c = 1; c <= done_c; c++) if (stall_log[c] !== 1'b1) bad++;
      n_cmp++; if (stall_log[0] !== 1'b0 || stall_log[done_c + 1] !== 1'b0) begin
        n_bad++; $display("FAIL %s_stall_idle got %b/%b want 0/0", nm, stall_log[0], stall_log[done_c + 1]);
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL %s_stall_busy got %0d low cycles want 0", nm, bad); end
    end
  endtask

  task automatic check_full_beats(input string nm);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (i >= nb || b_idx[i] !== AW'(i) || b_data[i] !== DW'(i * 3) || b_last[i] !== (i == N - 1)) begin
        n_bad++;
        $display("FAIL %s_beat%0d got idx=%0d data=%0d last=%b want idx=%0d data=%0d last=%b",
                 nm, i, b_idx[i], b_data[i], b_last[i], i, i * 3, (i == N - 1));
      end
    end
  endtask

  task automatic test_full_dump;
    preload(0);
    run_dump(1'b0, 1'b0, -1, 5);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL full_timeout got no done want done"); end
    n_cmp++; if (nb != N) begin n_bad++; $display("FAIL full_nbeats got %0d want %0d", nb, N); end
    check_full_beats("full");
    n_cmp++; if (first_v != 2) begin n_bad++; $display("FAIL full_first_valid got %0d want 2", first_v); end
    n_cmp++; if (done_c != 2 * N + 1) begin n_bad++; $display("FAIL full_done_cycle got %0d want %0d", done_c, 2 * N + 1); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL full_done_pulses got %0d want 1", done_cnt); end
    n_cmp++; if (emit_count !== 6'd32) begin n_bad++; $display("FAIL full_emit got %0d want 32", emit_count); end
    n_cmp++; if (regs[20] !== 32'd60) begin n_bad++; $display("FAIL full_gated_write got %h want 3c", regs[20]); end
    check_stall("full");
  endtask

  task automatic test_backpressure;
    run_dump(1'b0, 1'b1, -1, -1);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL bp_timeout got no done want done"); end
    n_cmp++; if (nb != N) begin n_bad++; $display("FAIL bp_nbeats got %0d want %0d", nb, N); end
    check_full_beats("bp");
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL bp_hold got %0d unstable want 0", hold_bad); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt); end
    n_cmp++; if (emit_count !== 6'd32) begin n_bad++; $display("FAIL bp_emit got %0d want 32", emit_count); end
    check_stall("bp");
  endtask

  task automatic test_restart_ignored;
    run_dump(1'b0, 1'b0, 10, -1);
    n_cmp++; if (nb != N) begin n_bad++; $display("FAIL restart_nbeats got %0d want %0d", nb, N); end
    check_full_beats("restart");
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL restart_done_pulses got %0d want 1", done_cnt); end
    n_cmp++; if (emit_count !== 6'd32) begin n_bad++; $display("FAIL restart_emit got %0d want 32", emit_count); end
  endtask

  task automatic test_skip_zero;
    preload(1);
    run_dump(1'b1, 1'b0, -1, -1);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL skip_timeout got no done want done"); end
    n_cmp++; if (nb != 2) begin n_bad++; $display("FAIL skip_nbeats got %0d want 2", nb); end
    n_cmp++; if (b_idx[0] !== 5'd5 || b_data[0] !== 32'hDEADBEEF || b_last[0] !== 1'b0) begin
      n_bad++; $display("FAIL skip_beat0 got %0d/%h/%b want 5/deadbeef/0", b_idx[0], b_data[0], b_last[0]);
    end
    n_cmp++; if (b_idx[1] !== 5'd31 || b_data[1] !== 32'h0 || b_last[1] !== 1'b1) begin
      n_bad++; $display("FAIL skip_beat1 got %0d/%h/%b want 31/0/1", b_idx[1], b_data[1], b_last[1]);
    end
    n_cmp++; if (emit_count !== 6'd2) begin n_bad++; $display("FAIL skip_emit got %0d want 2", emit_count); end
    check_stall("skip");
  endtask

  task automatic test_reset_mid_dump;
    bit found;
    found = 1'b0;
    preload(0);
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_index == 5'd7) begin
        out_ready = 1'b0;
        found = 1'b1;
      end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL midrst_reach got no idx7 beat want idx7 beat"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_state got valid=%b busy=%b want 0/0", out_valid, busy); end
    n_cmp++; if (emit_count !== '0) begin n_bad++; $display("FAIL midrst_emit got %0d want 0", emit_count); end
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) found = 1'b1;
    end
    n_cmp++; if (found) begin n_bad++; $display("FAIL midrst_quiet got done/busy activity want none"); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_restart_ignored();
    test_skip_zero();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side companion to the MIPS register file: on request, walks the file through a dedicated asynchronous read port and streams every register (index and value) out over a valid/ready handshake.
- Used by the debug/testbench path to snapshot architectural state without touching the datapath read ports.
- Asserts a stall to the core for the whole dump so no write-back can change registers mid-snapshot.

Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1).
- ADDR_W, 5, register index width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- skip_zero  input  1  latched at accepted start; 1 = suppress zero-valued registers (index NUM_REGS-1 always emitted).
- dump_reg  output  ADDR_W  read address driven to the register-file dump port.
- dump_data  input  DATA_W  asynchronous read data returned for dump_reg.
- cpu_stall  output  1  high whenever state != IDLE; core must block reg_write while high.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_index  output  ADDR_W  register index of current beat.
- out_data  output  DATA_W  register value of current beat.
- out_last  output  1  high on the beat with index NUM_REGS-1.
- busy  output  1  same as cpu_stall.
- done  output  1  one-cycle pulse after the final beat is accepted.
- emit_count  output  ADDR_W+1  beats accepted in the current/last dump.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; idx=0; dump_reg=0; out_valid=0; out_index=0; out_data=0; out_last=0; done=0; emit_count=0; skip latch=0. Reset asserted mid-dump aborts immediately; no done pulse.
- States: IDLE, FETCH, SEND, FIN.
- IDLE: start=1 -> FETCH; idx<=0; emit_count<=0; latch skip_zero. start is ignored in every other state.
- FETCH: dump_reg=idx (driven combinationally from idx). Capture dump_data into the out_data register and idx into out_index the same cycle.
  - If skip latch=1, dump_data==0 and idx!=NUM_REGS-1: idx<=idx+1, stay in FETCH.
  - Otherwise go to SEND with out_valid<=1 and out_last<=(idx==NUM_REGS-1).
- SEND: out_valid, out_index, out_data and out_last are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid<=0; emit_count<=emit_count+1.
  - If out_last: -> FIN; otherwise idx<=idx+1 and -> FETCH.
- FIN: done=1 for exactly one cycle, then -> IDLE. emit_count holds until the next accepted start.
- Latency: first out_valid 2 cycles after the start cycle. With out_ready held at 1 and skip off: 2 cycles per register; done rises on cycle 2*NUM_REGS+1 after start.
- Register 0 reads 0 by construction: emitted as 0 with skip off, skipped with skip on.
- No combinational path from out_ready to out_valid or out_data.
- cpu_stall/busy are asserted from the first FETCH cycle through FIN inclusive.

Test Plan:
- Reset during SEND (idx=7, out_valid=1) -> next edge: out_valid=0, busy=0, emit_count=0; no done pulse.
- Preload r[i]=i*3 for i=1..31, skip_zero=0, out_ready=1 -> 32 beats with index 0..31 and data 0,3,...,93; out_last only on index 31; done exactly 1 cycle; emit_count=32; first out_valid 2 cycles after start.
- Same preload, out_ready toggling 1,0,0,1 -> each beat held stable across the stall cycles; no beat lost or duplicated; emit_count=32.
- r[5]=0xDEADBEEF, r[31]=0, all other registers 0, skip_zero=1 -> exactly 2 beats: (5, 0xDEADBEEF) then (31, 0, last=1); emit_count=2.
- start pulsed again at beat 10 and skip_zero changed mid-dump -> both ignored; dump completes unchanged with 32 beats.
- Check cpu_stall=1 from the first FETCH cycle through FIN and 0 otherwise; an attempted reg_write gated by cpu_stall leaves the dumped values unchanged.
